imem_fetch_ctrl: RTL and testbench

//  Instruction-memory bridge between StageF's fetch port (I_Addr/I_REn/I_Data/I_Valid/busy) and a

---
 rtl/imem_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: bridge from the fetch stage port to a req/ack word memory.
// One outstanding demand fetch, flush kill, misalignment and timeout errors.
// Optional single-entry next-word prefetch buffer: define IMEM_PREFETCH_EN.
module imem_fetch_ctrl #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] req_addr,
   input  logic        req_en,
   input  logic        flush,
   output logic [31:0] rsp_data,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic        busy,
   output logic [29:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned      TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DEMAND   = 2'd1;
`ifdef IMEM_PREFETCH_EN
   localparam logic [1:0] S_PREFETCH = 2'd2;
`endif

   logic [1:0]       state, state_d;
   logic [29:0]      mem_addr_d;
   logic             mem_req_d;
   logic [31:0]      rsp_data_d;
   logic             rsp_valid_d, rsp_err_d;
   logic             kill, kill_d;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
   logic             new_req, aligned, tmo_hit, prefetch_hit;

   // A new request is only seen outside the response cycle
   assign new_req = req_en & ~rsp_valid;
   assign aligned = (req_addr[1:0] == 2'b00);
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

`ifdef IMEM_PREFETCH_EN
   logic [29:0] pf_addr, pf_addr_d;
   logic [31:0] pf_data, pf_data_d;
   logic        pf_valid, pf_valid_d, pf_want, pf_want_d, pf_match;

   // Buffer hit in IDLE, and promotion of an in-flight prefetch
   assign prefetch_hit = (state == S_IDLE) & new_req & aligned & ~flush & pf_valid &
                         (req_addr[31:2] == pf_addr);
   assign pf_match     = new_req & aligned & ~flush & ~kill & (req_addr[31:2] == mem_addr);
`else
   assign prefetch_hit = 1'b0;
`endif

   // F stalls while a fetch is outstanding or a fresh request waits for memory
   assign busy = reset & ((state != S_IDLE) | (new_req & ~prefetch_hit));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      mem_addr_d  = mem_addr;
      mem_req_d   = mem_req;
      rsp_data_d  = rsp_data;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      kill_d      = kill;
      tmo_cnt_d   = tmo_cnt;
`ifdef IMEM_PREFETCH_EN
      pf_addr_d   = pf_addr;
      pf_data_d   = pf_data;
      pf_valid_d  = pf_valid;
      pf_want_d   = pf_want;
`endif
      case (state)
         S_IDLE: begin
            if (new_req && !aligned) begin
               if (!flush) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = NOP_WORD;
               end
            end
`ifdef IMEM_PREFETCH_EN
            else if (prefetch_hit) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = pf_data;
               pf_valid_d  = 1'b0;
               pf_addr_d   = pf_addr + 30'd1;
               pf_want_d   = 1'b1;
            end
`endif
            else if (new_req) begin
               mem_addr_d = req_addr[31:2];
               mem_req_d  = 1'b1;
               state_d    = S_DEMAND;
               kill_d     = flush;
               tmo_cnt_d  = '0;
`ifdef IMEM_PREFETCH_EN
               pf_valid_d = 1'b0;
               pf_want_d  = 1'b0;
`endif
            end
`ifdef IMEM_PREFETCH_EN
            else if (pf_want && !flush) begin
               mem_addr_d = pf_addr;
               mem_req_d  = 1'b1;
               state_d    = S_PREFETCH;
               kill_d     = 1'b0;
               tmo_cnt_d  = '0;
               pf_want_d  = 1'b0;
            end
`endif
         end
         S_DEMAND: begin
            if (flush) kill_d = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               kill_d    = 1'b0;
               tmo_cnt_d = '0;
               if (!(kill || flush)) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = mem_rdata;
`ifdef IMEM_PREFETCH_EN
                  pf_addr_d   = mem_addr + 30'd1;
                  pf_want_d   = 1'b1;
                  pf_valid_d  = 1'b0;
`endif
               end
            end else if (tmo_hit) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               kill_d    = 1'b0;
               tmo_cnt_d = '0;
               if (!(kill || flush)) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = NOP_WORD;
               end
            end else begin
               tmo_cnt_d = tmo_cnt + 1'b1;
            end
         end
`ifdef IMEM_PREFETCH_EN
         S_PREFETCH: begin
            if (flush) kill_d = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               kill_d    = 1'b0;
               tmo_cnt_d = '0;
               if (!(kill || flush)) begin
                  if (pf_match) begin
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = mem_rdata;
                     pf_addr_d   = mem_addr + 30'd1;
                     pf_want_d   = 1'b1;
                  end else if (!new_req) begin
                     pf_valid_d = 1'b1;
                     pf_data_d  = mem_rdata;
                     pf_addr_d  = mem_addr;
                  end
               end
            end else if (pf_match) begin
               state_d   = S_DEMAND;
               tmo_cnt_d = '0;
            end else if (tmo_hit) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               kill_d    = 1'b0;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt + 1'b1;
            end
         end
`endif
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
`ifdef IMEM_PREFETCH_EN
      if (flush) begin
         pf_valid_d = 1'b0;
         pf_want_d  = 1'b0;
      end
      if (rsp_err_d) pf_valid_d = 1'b0;
`endif
   end

   // Registered memory-side and response outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_req   <= 1'b0;
         rsp_data  <= NOP_WORD;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         kill      <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         mem_addr  <= mem_addr_d;
         mem_req   <= mem_req_d;
         rsp_data  <= rsp_data_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         kill      <= kill_d;
         tmo_cnt   <= tmo_cnt_d;
      end
   end

`ifdef IMEM_PREFETCH_EN
   // Next-word buffer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pf_addr  <= '0;
         pf_data  <= NOP_WORD;
         pf_valid <= 1'b0;
         pf_want  <= 1'b0;
      end else begin
         pf_addr  <= pf_addr_d;
         pf_data  <= pf_data_d;
         pf_valid <= pf_valid_d;
         pf_want  <= pf_want_d;
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: scoreboard of expected responses plus directed
// handshake checks; a second instance with a short timeout and no memory ack.
module tb_imem_fetch_ctrl;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_en = 1'b0;
   logic        flush = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] rsp_data;
   logic        rsp_valid, rsp_err, busy, mem_req;
   logic [29:0] mem_addr;

   logic        req_en_t = 1'b0;
   logic [31:0] rsp_data_t;
   logic        rsp_valid_t, rsp_err_t, busy_t, mem_req_t;
   logic [29:0] mem_addr_t;

   int   n_chk = 0;
   int   n_bad = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   logic prev_v = 1'b0;

   always #5 clk = ~clk;

   imem_fetch_ctrl u_dut (
      .clk(clk), .reset(reset), .req_addr(req_addr), .req_en(req_en), .flush(flush),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   imem_fetch_ctrl #(.TIMEOUT(4)) u_dut_t (
      .clk(clk), .reset(reset), .req_addr(req_addr), .req_en(req_en_t), .flush(1'b0),
      .rsp_data(rsp_data_t), .rsp_valid(rsp_valid_t), .rsp_err(rsp_err_t), .busy(busy_t),
      .mem_addr(mem_addr_t), .mem_req(mem_req_t), .mem_ack(1'b0), .mem_rdata(32'h0)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every response pops the oldest expectation
   always @(negedge clk) begin
      if (!reset) begin
         prev_v = 1'b0;
      end else begin
         if (rsp_valid) begin
            check_val("rsp_b2b", 32'(prev_v), 32'h0);
            if (sb_q.size() == 0) begin
               check_val("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("rsp_data", rsp_data, mon_e.data);
               check_val("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
         end
         prev_v = rsp_valid;
      end
   end

   // Aligned demand fetch; memory acks after nwait extra cycles
   task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] data, input int nwait);
      exp_t e;
      e.data = data;
      e.err  = 1'b0;
      sb_q.push_back(e);
      req_addr = addr;
      req_en   = 1'b1;
      #1 check_val("busy_req", 32'(busy), 32'h1);
      tick();
      check_val("mreq_up", 32'(mem_req), 32'h1);
      check_val("maddr", 32'(mem_addr), 32'(addr[31:2]));
      for (int i = 0; i < nwait; i++) begin
         tick();
         check_val("mreq_hold", 32'(mem_req), 32'h1);
      end
      mem_ack   = 1'b1;
      mem_rdata = data;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check_val("rsp_vld", 32'(rsp_valid), 32'h1);
      check_val("mreq_drop", 32'(mem_req), 32'h0);
      req_en = 1'b0;
      tick();
`ifdef IMEM_PREFETCH_EN
      check_val("pf_req", 32'(mem_req), 32'h1);
      check_val("pf_addr", 32'(mem_addr), 32'(addr[31:2] + 30'd1));
      mem_ack   = 1'b1;
      mem_rdata = ~data;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check_val("pf_drop", 32'(mem_req), 32'h0);
`endif
   endtask

   // Misaligned request: error response next cycle, no memory access
   task automatic fetch_mis(input logic [31:0] addr);
      exp_t e;
      e.data = 32'h0;
      e.err  = 1'b1;
      sb_q.push_back(e);
      req_addr = addr;
      req_en   = 1'b1;
      tick();
      check_val("mis_vld", 32'(rsp_valid), 32'h1);
      check_val("mis_err", 32'(rsp_err), 32'h1);
      check_val("mis_mreq", 32'(mem_req), 32'h0);
      tick();
      check_val("mis_once", 32'(rsp_valid), 32'h0);
      check_val("mis_mreq2", 32'(mem_req), 32'h0);
      req_en = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_data", rsp_data, 32'h0);
      check_val("rst_vld", 32'(rsp_valid), 32'h0);
      check_val("rst_err", 32'(rsp_err), 32'h0);
      check_val("rst_mreq", 32'(mem_req), 32'h0);
      check_val("rst_maddr", 32'(mem_addr), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      tick();

      // 1: aligned fetch, ack in first mem_req cycle
      fetch_ok(32'h0000_3000, 32'h3C01_ABCD, 0);

      // 2: misaligned fetch
      fetch_mis(32'h0000_3002);

      // 3: flush in second demand cycle, ack three cycles later
      req_addr = 32'h0000_3004;
      req_en   = 1'b1;
      tick();
      check_val("fl_mreq", 32'(mem_req), 32'h1);
      check_val("fl_maddr", 32'(mem_addr), 32'h0000_0C01);
      tick();
      flush  = 1'b1;
      req_en = 1'b0;
      tick();
      flush = 1'b0;
      check_val("fl_hold1", 32'(mem_req), 32'h1);
      check_val("fl_busy", 32'(busy), 32'h1);
      tick();
      check_val("fl_hold2", 32'(mem_req), 32'h1);
      tick();
      check_val("fl_hold3", 32'(mem_req), 32'h1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check_val("fl_drop", 32'(mem_req), 32'h0);
      check_val("fl_novld", 32'(rsp_valid), 32'h0);
      tick();
      check_val("fl_novld2", 32'(rsp_valid), 32'h0);
      check_val("fl_idle", 32'(busy), 32'h0);
      fetch_ok(32'h0000_4180, 32'h8C22_0010, 2);

      // 4: timeout with memory never acking (TIMEOUT=4 instance)
      req_addr = 32'h0000_5000;
      req_en_t = 1'b1;
      tick();
      check_val("tmo_maddr", 32'(mem_addr_t), 32'h0000_1400);
      n = 0;
      while (mem_req_t && n < 20) begin
         n++;
         tick();
      end
      check_val("tmo_len", 32'(n), 32'h4);
      check_val("tmo_vld", 32'(rsp_valid_t), 32'h1);
      check_val("tmo_err", 32'(rsp_err_t), 32'h1);
      check_val("tmo_data", rsp_data_t, 32'h0);
      check_val("tmo_busy", 32'(busy_t), 32'h0);
      req_en_t = 1'b0;
      tick();
      check_val("tmo_once", 32'(rsp_valid_t), 32'h0);

      // 5: reset in the middle of a demand
      req_addr = 32'h0000_6000;
      req_en   = 1'b1;
      tick();
      tick();
      check_val("mr_mreq", 32'(mem_req), 32'h1);
      #2;
      reset  = 1'b0;
      req_en = 1'b0;
      #1;
      check_val("mr_mreq_low", 32'(mem_req), 32'h0);
      check_val("mr_vld_low", 32'(rsp_valid), 32'h0);
      check_val("mr_busy_low", 32'(busy), 32'h0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      fetch_ok(32'h0000_6000, 32'h1111_2222, 1);

      // Address boundaries and other patterns
      fetch_ok(32'hFFFF_FFFC, 32'hCAFE_F00D, 3);
      fetch_ok(32'h0000_0000, 32'h1234_5678, 0);
      fetch_mis(32'h0000_0007);
      fetch_mis(32'h8000_0001);

`ifdef IMEM_PREFETCH_EN
      // 6: next word served from the prefetch buffer, then a miss
      fetch_ok(32'h0000_3000, 32'h3C01_ABCD, 0);
      begin
         exp_t e;
         e.data = ~32'h3C01_ABCD;
         e.err  = 1'b0;
         sb_q.push_back(e);
      end
      req_addr = 32'h0000_3004;
      req_en   = 1'b1;
      #1 check_val("pf_hit_busy", 32'(busy), 32'h0);
      tick();
      check_val("pf_hit_vld", 32'(rsp_valid), 32'h1);
      check_val("pf_hit_mreq", 32'(mem_req), 32'h0);
      req_en = 1'b0;
      tick();
      check_val("pf_next_req", 32'(mem_req), 32'h1);
      check_val("pf_next_addr", 32'(mem_addr), 32'h0000_0C02);
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA_55AA;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check_val("pf_next_drop", 32'(mem_req), 32'h0);
      fetch_ok(32'h0000_3100, 32'h0BAD_F00D, 1);
`endif

      repeat (3) tick();
      check_val("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
